// File: rtl/sdram_bridge_pkg.sv
// sdram_bridge_pkg: shared FSM state type and SDRAM address-window check for the APB bridge
package sdram_bridge_pkg;

    typedef enum logic [2:0] {IDLE, ISSUE, WAIT_ACK, RESP, ERR, NOP} bridge_state_t;

    // Both operands are zero-extended by the caller, so comparing above size_log2 is a window hit
    function automatic logic in_window(input logic [63:0] addr, input logic [63:0] base,
                                       input int unsigned size_log2);
        return (addr >> size_log2) == (base >> size_log2);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: round-robin arbiter; the requester after the last winner has highest priority
module rr_arbiter #(
    parameter int N = 2,
    localparam int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic          clock,
    input  logic          reset,
    input  logic [N-1:0]  req_i,
    input  logic          advance_i,
    output logic [N-1:0]  grant_o,
    output logic [IW-1:0] grant_idx_o
);

    logic [IW-1:0] ptr_q, ptr_d;
    logic          found;

    always_ff @(posedge clock) begin
        if (reset) ptr_q <= IW'(N - 1);
        else       ptr_q <= ptr_d;
    end

    // Second loop overrides the first, so ports above the pointer beat the wrapped-around ones
    always_comb begin
        found = |req_i;
        grant_idx_o = '0;
        for (int p = N - 1; p >= 0; p--)
            if (req_i[p] && p <= int'(ptr_q)) grant_idx_o = IW'(p);
        for (int p = N - 1; p >= 0; p--)
            if (req_i[p] && p > int'(ptr_q)) grant_idx_o = IW'(p);
        grant_o = found ? N'(1) << grant_idx_o : '0;
        ptr_d = (advance_i && found) ? grant_idx_o : ptr_q;
    end

endmodule

// File: rtl/sdram_apb_arb_bridge.sv
// sdram_apb_arb_bridge: round-robin multi-port APB front end for the SDRAM core req/accept/ack interface
module sdram_apb_arb_bridge
    import sdram_bridge_pkg::*;
#(
    parameter int                NUM_PORTS = 2,
    parameter int                ADDR_W    = 32,
    parameter int                DATA_W    = 32,
    parameter logic [ADDR_W-1:0] BASE_ADDR = 32'hA000_0000,
    parameter int unsigned       SIZE_LOG2 = 25,
    localparam int               STRB_W    = DATA_W / 8,
    localparam int               IW        = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic [NUM_PORTS-1:0]          in_psel,
    input  logic [NUM_PORTS-1:0]          in_penable,
    input  logic [NUM_PORTS-1:0]          in_pwrite,
    input  logic [NUM_PORTS*ADDR_W-1:0]   in_paddr,
    input  logic [NUM_PORTS*DATA_W-1:0]   in_pwdata,
    input  logic [NUM_PORTS*STRB_W-1:0]   in_pstrb,
    input  logic [NUM_PORTS*3-1:0]        in_pprot,
    output logic [NUM_PORTS-1:0]          in_pready,
    output logic [NUM_PORTS*DATA_W-1:0]   in_prdata,
    output logic [NUM_PORTS-1:0]          in_pslverr,
    output logic [STRB_W-1:0]             core_wr_o,
    output logic                          core_rd_o,
    output logic [ADDR_W-1:0]             core_addr_o,
    output logic [DATA_W-1:0]             core_wdata_o,
    input  logic                          core_accept_i,
    input  logic                          core_ack_i,
    input  logic                          core_error_i,
    input  logic [DATA_W-1:0]             core_rdata_i
);

    localparam logic [ADDR_W-1:0] OFFS_MASK = ADDR_W'((64'd1 << SIZE_LOG2) - 64'd1);

    bridge_state_t        state_q, state_d;
    logic [IW-1:0]        gnt_q, gnt_d, gnt_idx;
    logic [NUM_PORTS-1:0] gnt_oh;
    logic [ADDR_W-1:0]    addr_q, addr_d, paddr_g;
    logic [DATA_W-1:0]    wdata_q, wdata_d, rdata_q, rdata_d;
    logic [STRB_W-1:0]    strb_q, strb_d, pstrb_g;
    logic                 write_q, write_d, err_q, err_d, start;
    logic                 unused;

    assign start        = state_q == IDLE && |in_psel;
    assign paddr_g      = in_paddr[gnt_idx*ADDR_W +: ADDR_W];
    assign pstrb_g      = in_pstrb[gnt_idx*STRB_W +: STRB_W];
    assign core_addr_o  = addr_q;
    assign core_wdata_o = wdata_q;
    assign unused       = ^{in_penable, in_pprot, gnt_oh};

    rr_arbiter #(.N(NUM_PORTS)) u_arb (
        .clock       (clock),
        .reset       (reset),
        .req_i       (in_psel),
        .advance_i   (start),
        .grant_o     (gnt_oh),
        .grant_idx_o (gnt_idx)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            strb_q  <= '0;
            write_q <= 1'b0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            strb_q  <= strb_d;
            write_q <= write_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        gnt_d      = gnt_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        strb_d     = strb_q;
        write_d    = write_q;
        rdata_d    = rdata_q;
        err_d      = err_q;
        core_rd_o  = 1'b0;
        core_wr_o  = '0;
        in_pready  = '0;
        in_pslverr = '0;
        in_prdata  = '0;
        case (state_q)
            IDLE: if (start) begin
                gnt_d   = gnt_idx;
                addr_d  = paddr_g & OFFS_MASK;
                wdata_d = in_pwdata[gnt_idx*DATA_W +: DATA_W];
                strb_d  = pstrb_g;
                write_d = in_pwrite[gnt_idx];
                state_d = !in_window(64'(paddr_g), 64'(BASE_ADDR), SIZE_LOG2) ? ERR
                        : (in_pwrite[gnt_idx] && pstrb_g == '0) ? NOP : ISSUE;
            end
            ISSUE: begin
                core_rd_o = !write_q;
                core_wr_o = write_q ? strb_q : '0;
                if (core_accept_i) state_d = core_ack_i ? RESP : WAIT_ACK;
            end
            WAIT_ACK: if (core_ack_i) state_d = RESP;
            RESP, ERR, NOP: begin
                in_pready[gnt_q]  = 1'b1;
                in_pslverr[gnt_q] = state_q == ERR || (state_q == RESP && err_q);
                in_prdata[gnt_q*DATA_W +: DATA_W] = (state_q == RESP && !write_q) ? rdata_q : '0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (core_ack_i && ((state_q == ISSUE && core_accept_i) || state_q == WAIT_ACK)) begin
            rdata_d = core_rdata_i;
            err_d   = core_error_i;
        end
    end

endmodule

// File: tb/tb_sdram_apb_arb_bridge.sv
// tb_sdram_apb_arb_bridge: directed and randomized APB transfers checked against a transaction-level model
module tb_sdram_apb_arb_bridge;

    localparam int          NP   = 2;
    localparam int          AW   = 32;
    localparam int          DW   = 32;
    localparam int          SW   = DW / 8;
    localparam int          SL   = 25;
    localparam logic [31:0] BASE = 32'hA000_0000;

    logic           clock = 1'b0;
    logic           reset;
    logic [NP-1:0]  psel, penable, pwrite, pready, pslverr;
    logic [NP*AW-1:0] paddr;
    logic [NP*DW-1:0] pwdata, prdata;
    logic [NP*SW-1:0] pstrb;
    logic [NP*3-1:0]  pprot;
    logic [SW-1:0]  core_wr;
    logic           core_rd, core_accept, core_ack, core_error;
    logic [AW-1:0]  core_addr;
    logic [DW-1:0]  core_wdata, core_rdata;

    logic [31:0] t_addr [NP];
    logic [31:0] t_wdata[NP];
    logic [3:0]  t_strb [NP];
    logic        t_write[NP];
    bit          pending[NP];
    int          last;
    int          checks = 0, errors = 0;
    int          lat;

    always #5 clock = ~clock;

    sdram_apb_arb_bridge dut (
        .clock        (clock),
        .reset        (reset),
        .in_psel      (psel),
        .in_penable   (penable),
        .in_pwrite    (pwrite),
        .in_paddr     (paddr),
        .in_pwdata    (pwdata),
        .in_pstrb     (pstrb),
        .in_pprot     (pprot),
        .in_pready    (pready),
        .in_prdata    (prdata),
        .in_pslverr   (pslverr),
        .core_wr_o    (core_wr),
        .core_rd_o    (core_rd),
        .core_addr_o  (core_addr),
        .core_wdata_o (core_wdata),
        .core_accept_i(core_accept),
        .core_ack_i   (core_ack),
        .core_error_i (core_error),
        .core_rdata_i (core_rdata)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(negedge clock);
        penable = psel;
    endtask

    task automatic set_req(input int p, input logic [31:0] a, input logic w,
                           input logic [31:0] d, input logic [3:0] s);
        psel[p] = 1'b1;
        penable[p] = 1'b0;
        pwrite[p] = w;
        paddr[p*AW +: AW] = a;
        pwdata[p*DW +: DW] = d;
        pstrb[p*SW +: SW] = s;
        pprot[p*3 +: 3] = 3'($urandom);
        t_addr[p] = a;
        t_wdata[p] = d;
        t_strb[p] = s;
        t_write[p] = w;
        pending[p] = 1'b1;
    endtask

    function automatic int next_grant();
        for (int k = 1; k <= NP; k++)
            if (pending[(last + k) % NP]) return (last + k) % NP;
        return -1;
    endfunction

    function automatic logic [31:0] rand_addr();
        return ($urandom_range(0, 3) == 0) ? 32'($urandom) : BASE + ($urandom % (32'd1 << SL));
    endfunction

    // Serve one transfer expected on port g; entered and left at a negedge with the bridge idle
    task automatic serve(input int g, input int hold, input int ackdly,
                         input logic [31:0] rd, input logic er, output int n);
        logic        inwin, core;
        logic [3:0]  ewr;
        logic [63:0] eprd;
        last  = g;
        inwin = (t_addr[g] >> SL) == (BASE >> SL);
        core  = inwin && !(t_write[g] && t_strb[g] == 4'd0);
        ewr   = t_write[g] ? t_strb[g] : 4'd0;
        n = 0;
        while (!core_rd && core_wr == '0 && pready == '0 && n < 20) begin
            step();
            n++;
        end
        check("wait_bound", n < 20, 1);
        if (core) begin
            check("core_rd", core_rd, !t_write[g]);
            check("core_wr", core_wr, ewr);
            check("core_addr", core_addr, t_addr[g] - BASE);
            if (t_write[g]) check("core_wdata", core_wdata, t_wdata[g]);
            check("pready_early", pready, 0);
            for (int i = 0; i < hold; i++) begin
                step();
                n++;
                check("hold_rd", core_rd, !t_write[g]);
                check("hold_wr", core_wr, ewr);
                check("hold_addr", core_addr, t_addr[g] - BASE);
            end
            core_accept = 1'b1;
            if (ackdly == 0) begin
                core_ack = 1'b1;
                core_rdata = rd;
                core_error = er;
            end
            step();
            n++;
            core_accept = 1'b0;
            core_ack = 1'b0;
            if (ackdly > 0) begin
                check("wait_ack_idle", {core_rd, core_wr}, 0);
                for (int i = 1; i < ackdly; i++) begin
                    step();
                    n++;
                end
                core_ack = 1'b1;
                core_rdata = rd;
                core_error = er;
                step();
                n++;
                core_ack = 1'b0;
            end
            core_rdata = $urandom;
            core_error = 1'($urandom);
        end
        eprd = '0;
        if (core && !t_write[g]) eprd[g*DW +: DW] = rd;
        check("pready", pready, 64'(1) << g);
        check("pslverr", pslverr, (!inwin || (core && er)) ? 64'(1) << g : 64'd0);
        check("prdata", prdata, eprd);
        check("core_quiet", {core_rd, core_wr}, 0);
        psel[g] = 1'b0;
        penable[g] = 1'b0;
        pending[g] = 1'b0;
        step();
        check("pready_1cyc", pready, 0);
    endtask

    initial begin
        reset = 1'b1;
        psel = '0; penable = '0; pwrite = '0; paddr = '0; pwdata = '0; pstrb = '0; pprot = '0;
        core_accept = 1'b0; core_ack = 1'b0; core_error = 1'b0; core_rdata = '0;
        last = NP - 1;
        for (int p = 0; p < NP; p++) pending[p] = 1'b0;
        step();
        step();
        check("reset_outs", |{pready, pslverr, prdata, core_wr, core_rd, core_addr, core_wdata}, 0);
        reset = 1'b0;
        step();

        set_req(0, 32'hA000_0010, 1'b0, 32'h0, 4'hF);
        serve(next_grant(), 0, 1, 32'hDEADBEEF, 1'b0, lat);
        check("read_latency", lat, 3);

        set_req(1, 32'hA000_0004, 1'b1, 32'h1234_5678, 4'b0011);
        serve(next_grant(), 0, 1, 32'hFFFF_FFFF, 1'b0, lat);

        for (int r = 0; r < 2; r++) begin
            set_req(0, BASE + 32'h40 + 32'(r), 1'b0, 32'h0, 4'hF);
            set_req(1, BASE + 32'h80 + 32'(r), 1'b1, 32'($urandom), 4'hF);
            while (next_grant() >= 0) serve(next_grant(), 0, 1, 32'($urandom), 1'b0, lat);
        end

        set_req(0, 32'h8000_0000, 1'b0, 32'h0, 4'hF);
        serve(next_grant(), 0, 1, 32'h0, 1'b0, lat);

        set_req(1, BASE + 32'h20, 1'b1, 32'hCAFE_F00D, 4'b0000);
        serve(next_grant(), 0, 1, 32'h0, 1'b0, lat);

        set_req(0, BASE + 32'h30, 1'b0, 32'h0, 4'hF);
        serve(next_grant(), 5, 1, 32'h5555_AAAA, 1'b0, lat);

        set_req(1, BASE + 32'h34, 1'b0, 32'h0, 4'hF);
        serve(next_grant(), 1, 2, 32'h0BAD_0BAD, 1'b1, lat);

        // Reset lands while the bridge waits for the core ack
        set_req(0, BASE + 32'h100, 1'b0, 32'h0, 4'hF);
        step();
        check("pre_reset_rd", core_rd, 1);
        core_accept = 1'b1;
        step();
        core_accept = 1'b0;
        check("pre_reset_wait", core_rd, 0);
        reset = 1'b1;
        step();
        check("mid_reset_outs", |{pready, pslverr, prdata, core_wr, core_rd, core_addr, core_wdata}, 0);
        reset = 1'b0;
        psel = '0;
        penable = '0;
        for (int p = 0; p < NP; p++) pending[p] = 1'b0;
        last = NP - 1;
        set_req(0, BASE + 32'h200, 1'b0, 32'h0, 4'hF);
        serve(next_grant(), 0, 1, 32'h7777_1234, 1'b0, lat);
        check("post_reset_latency", lat, 3);

        for (int it = 0; it < 40; it++) begin
            int mask, extra, g;
            mask = $urandom_range(1, (1 << NP) - 1);
            extra = 0;
            for (int p = 0; p < NP; p++)
                if (mask[p]) set_req(p, rand_addr(), 1'($urandom), 32'($urandom),
                                     ($urandom_range(0, 4) == 0) ? 4'd0 : 4'($urandom));
            while (next_grant() >= 0) begin
                g = next_grant();
                serve(g, $urandom_range(0, 3), $urandom_range(0, 2), 32'($urandom),
                      1'($urandom_range(0, 4) == 0), lat);
                if (extra < 3 && next_grant() >= 0 && $urandom_range(0, 2) == 0) begin
                    set_req(g, rand_addr(), 1'($urandom), 32'($urandom), 4'($urandom));
                    extra++;
                end
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
